// File: rtl/reg_burst_seq.sv
// reg_burst_seq: burst sequencer driving ld/inc/clr of an external address register.
// One beat per valid/ready handshake; the register is cleared at burst end or abort.
module reg_burst_seq #(
   parameter int AW = 16,
   parameter int LW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic [LW-1:0] len,
   input  logic          abort,
   input  logic          beat_rdy,
   output logic          beat_vld,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic          reg_ld,
   output logic          reg_inc,
   output logic          reg_clr,
   output logic [AW-1:0] reg_din
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] BURST = 3'd2;
   localparam logic [2:0] DONE  = 3'd3;
   localparam logic [2:0] ABRT  = 3'd4;
   logic [2:0]    state_q, state_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [AW-1:0] din_q, din_d;
   logic          accept;
   always_comb begin
      beat_vld = (state_q == BURST) & ~abort;
      accept   = beat_vld & beat_rdy;
      reg_inc  = accept & (rem_q != LW'(1));
      state_d  = state_q;
      rem_d    = rem_q;
      din_d    = din_q;
      case (state_q)
         IDLE: begin
            if (start && len != '0) begin
               state_d = LOAD;
               rem_d   = len;
               din_d   = start_addr;
            end else if (start) begin
               state_d = DONE;
            end
         end
         LOAD: state_d = abort ? ABRT : BURST;
         BURST: begin
            // abort wins over ready: the offered beat is withdrawn, rem untouched
            if (abort) begin
               state_d = ABRT;
            end else if (accept) begin
               rem_d   = rem_q - LW'(1);
               state_d = (rem_q == LW'(1)) ? DONE : BURST;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         din_q   <= din_d;
      end
   end
   assign busy    = state_q != IDLE;
   assign done    = state_q == DONE;
   assign aborted = state_q == ABRT;
   assign reg_ld  = state_q == LOAD;
   assign reg_clr = (state_q == DONE) | (state_q == ABRT);
   assign reg_din = din_q;
endmodule

// File: tb/tb_reg_burst_seq.sv
// tb_reg_burst_seq: directed bench with an expected-event scoreboard for reg_burst_seq.
// A model of the external register follows ld/inc/clr and checks every accepted beat address.
module tb_reg_burst_seq;
   logic        clk = 0, rst = 1, start = 0, abort = 0, beat_rdy = 0;
   logic [15:0] start_addr = '0;
   logic [7:0]  len = '0;
   logic        beat_vld, busy, done, aborted, reg_ld, reg_inc, reg_clr;
   logic [15:0] reg_din;
   typedef struct {
      int          k;
      logic [15:0] a;
   } ev_t;
   ev_t         q[$];
   int          checks = 0, errors = 0;
   int          ld_cnt = 0, inc_cnt = 0, clr_cnt = 0, vld_cnt = 0, done_cnt = 0, ab_cnt = 0;
   logic [15:0] rm = '0;
   reg_burst_seq #(.AW(16), .LW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
      .abort(abort), .beat_rdy(beat_rdy), .beat_vld(beat_vld), .busy(busy),
      .done(done), .aborted(aborted), .reg_ld(reg_ld), .reg_inc(reg_inc),
      .reg_clr(reg_clr), .reg_din(reg_din)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic pop_chk(input int k, input logic [15:0] a);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL sb_unexpected: got event %0d addr %0h expected none", k, a);
      end else begin
         e = q.pop_front();
         if (e.k != k || (k == 0 && e.a !== a)) begin
            errors++;
            $display("FAIL sb_event: got event %0d addr %0h expected event %0d addr %0h", k, a, e.k, e.a);
         end
      end
   endtask
   // kind 0 = accepted beat, 1 = done, 2 = aborted; rm is updated after the compare
   always @(negedge clk) begin
      if (!rst) begin
         chk("ld_inc_clr_excl", 32'(int'(reg_ld) + int'(reg_inc) + int'(reg_clr) <= 1), 32'd1);
         if (reg_ld) ld_cnt++;
         if (reg_inc) inc_cnt++;
         if (reg_clr) clr_cnt++;
         if (beat_vld) vld_cnt++;
         if (beat_vld && beat_rdy) pop_chk(0, rm);
         if (done) begin done_cnt++; pop_chk(1, '0); end
         if (aborted) begin ab_cnt++; pop_chk(2, '0); end
         rm = reg_ld ? reg_din : reg_inc ? rm + 16'd1 : reg_clr ? 16'd0 : rm;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push_burst(input logic [15:0] a, input int n);
      for (int i = 0; i < n; i++) q.push_back('{0, a + 16'(i)});
      q.push_back('{1, 16'd0});
   endtask
   task automatic start_cmd(input logic [15:0] a, input int n);
      start = 1;
      start_addr = a;
      len = 8'(n);
      tick();
      start = 0;
      len = '0;
   endtask
   task automatic wait_end(input int budget);
      int d0 = done_cnt + ab_cnt;
      int k = 0;
      while (done_cnt + ab_cnt == d0 && k < budget) begin
         tick();
         k++;
      end
      chk("end_timeout", 32'(done_cnt + ab_cnt != d0), 32'd1);
   endtask
   task automatic full_burst(input logic [15:0] a, input int n, input string tag);
      int i0 = inc_cnt, l0 = ld_cnt, c0 = clr_cnt, v0 = vld_cnt;
      beat_rdy = 1;
      push_burst(a, n);
      start_cmd(a, n);
      chk({tag, "_ld"}, reg_ld, 1);
      chk({tag, "_vld_in_load"}, beat_vld, 0);
      chk({tag, "_busy"}, busy, 1);
      tick();
      chk({tag, "_first_vld"}, beat_vld, 1);
      wait_end(n + 10);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_inc_cnt"}, 32'(inc_cnt - i0), 32'(n - 1));
      chk({tag, "_ld_cnt"}, 32'(ld_cnt - l0), 32'd1);
      chk({tag, "_clr_cnt"}, 32'(clr_cnt - c0), 32'd1);
      chk({tag, "_vld_cnt"}, 32'(vld_cnt - v0), 32'(n));
   endtask
   initial begin
      int pat[6] = '{0, 1, 0, 0, 1, 1};
      int i0, l0, v0, c0, d0;
      #3;
      chk("rst_outs", {beat_vld, busy, done, aborted, reg_ld, reg_inc, reg_clr}, 0);
      chk("rst_din", reg_din, 0);
      tick();
      tick();
      rst = 0;
      full_burst(16'h1000, 4, "b4");
      // back-pressure
      beat_rdy = 0;
      v0 = vld_cnt;
      push_burst(16'h1100, 3);
      start_cmd(16'h1100, 3);
      tick();
      for (int i = 0; i < 6; i++) begin
         beat_rdy = pat[i][0];
         #1;
         chk("bp_vld", beat_vld, 1);
         tick();
      end
      chk("bp_done", done, 1);
      chk("bp_vld_cnt", 32'(vld_cnt - v0), 32'd6);
      tick();
      beat_rdy = 1;
      // empty command
      l0 = ld_cnt;
      v0 = vld_cnt;
      q.push_back('{1, 16'd0});
      start_cmd(16'h5555, 0);
      chk("empty_done", done, 1);
      chk("empty_clr", reg_clr, 1);
      chk("empty_ld", reg_ld, 0);
      tick();
      chk("empty_idle", busy, 0);
      chk("empty_no_ld", 32'(ld_cnt - l0), 0);
      chk("empty_no_vld", 32'(vld_cnt - v0), 0);
      // start while busy is dropped
      l0 = ld_cnt;
      v0 = vld_cnt;
      push_burst(16'h3000, 2);
      start_cmd(16'h3000, 2);
      tick();
      start = 1;
      start_addr = 16'h7777;
      len = 8'd7;
      tick();
      start = 0;
      len = '0;
      wait_end(10);
      chk("busy_start_ld", 32'(ld_cnt - l0), 1);
      chk("busy_start_vld", 32'(vld_cnt - v0), 2);
      chk("busy_start_din", reg_din, 16'h3000);
      // abort on second BURST cycle
      d0 = done_cnt;
      i0 = inc_cnt;
      q.push_back('{0, 16'h2000});
      q.push_back('{2, 16'd0});
      start_cmd(16'h2000, 5);
      tick();
      tick();
      abort = 1;
      #1;
      chk("abort_vld", beat_vld, 0);
      chk("abort_inc", reg_inc, 0);
      tick();
      abort = 0;
      chk("abort_pulse", aborted, 1);
      chk("abort_clr", reg_clr, 1);
      chk("abort_no_done", done, 0);
      tick();
      chk("abort_done_cnt", 32'(done_cnt - d0), 0);
      chk("abort_inc_cnt", 32'(inc_cnt - i0), 1);
      full_burst(16'h2100, 1, "post_abort");
      // asynchronous reset mid-burst
      push_burst(16'h4000, 6);
      start_cmd(16'h4000, 6);
      tick();
      tick();
      #2;
      rst = 1;
      #1;
      chk("arst_outs", {beat_vld, busy, done, aborted, reg_ld, reg_inc, reg_clr}, 0);
      chk("arst_din", reg_din, 0);
      tick();
      rst = 0;
      q.delete();
      c0 = clr_cnt;
      tick();
      tick();
      chk("arst_no_clr", 32'(clr_cnt - c0), 0);
      chk("arst_idle", busy, 0);
      full_burst(16'h1000, 4, "after_rst");
      full_burst(16'hFFFE, 255, "wrap");
      chk("sb_empty", 32'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
